ram_wr_ctrl_frame: RTL and testbench

RAM_WR_CTRL_FRAME -- requirements
Module: ram_wr_ctrl_frame

---
 rtl/ram_wr_pkg.sv | 13 +
 rtl/peak_track.sv | 27 ++
 rtl/ram_wr_ctrl_frame.sv | 80 ++++++++
 tb/tb_ram_wr_ctrl_frame.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/ram_wr_pkg.sv
// ram_wr_pkg: shared FSM state encoding and default parameters for ram_wr_ctrl_frame
package ram_wr_pkg;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_SKIP  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam int DEF_DATA_W    = 16;
  localparam int DEF_ADDR_W    = 8;
  localparam int DEF_FRAME_LEN = 255;
  localparam int DEF_SKIP_LEN  = 0;
  localparam int DEF_CONT      = 0;
endpackage

// File: rtl/peak_track.sv
// peak_track: running maximum of written samples (lowest address wins ties); ports clk, rst, clear, load, data, addr -> peak_val, peak_addr
module peak_track #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic [DATA_W-1:0] data,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] peak_val,
  output logic [ADDR_W-1:0] peak_addr
);
  logic have;
  always_ff @(posedge clk) begin
    if (rst || (clear && !load)) begin
      have      <= 1'b0;
      peak_val  <= '0;
      peak_addr <= '0;
    end else if (load && (clear || !have || data > peak_val)) begin
      have      <= 1'b1;
      peak_val  <= data;
      peak_addr <= addr;
    end
  end
endmodule

// File: rtl/ram_wr_ctrl_frame.sv
// ram_wr_ctrl_frame: frame capture into RAM write port; ports clk, rst, start, data_in/valid/sof -> wr_data/addr/en, wr_done, busy, peak_val/addr, sof_err
module ram_wr_ctrl_frame import ram_wr_pkg::*; #(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int FRAME_LEN = DEF_FRAME_LEN,
  parameter int SKIP_LEN  = DEF_SKIP_LEN,
  parameter int CONT      = DEF_CONT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  input  logic              data_sof,
  output logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_en,
  output logic              wr_done,
  output logic              busy,
  output logic [DATA_W-1:0] peak_val,
  output logic [ADDR_W-1:0] peak_addr,
  output logic              sof_err
);
  if (FRAME_LEN < 1 || FRAME_LEN > (1 << ADDR_W)) begin : g_bad_len
    $error("FRAME_LEN must be within 1..2**ADDR_W");
  end
  localparam int SW = $clog2(SKIP_LEN + 1) + 1;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_LEN - 1);
  localparam logic [SW-1:0] SKIP_LAST = SW'(SKIP_LEN - 1);
  logic [2:0] state, state_nx;
  logic [SW-1:0] skip_cnt;
  logic [ADDR_W-1:0] waddr, addr_now;
  logic in_cap, restart, begin_f, wr_now, last, rearm;
  assign busy = in_cap;
  always_comb begin
    in_cap   = (state == S_SKIP) || (state == S_WRITE);
    restart  = data_valid && data_sof && in_cap;
    begin_f  = data_valid && data_sof && (in_cap || state == S_WAIT);
    wr_now   = begin_f ? (SKIP_LEN == 0) : (data_valid && state == S_WRITE);
    addr_now = begin_f ? '0 : waddr;
    last     = wr_now && addr_now == LAST;
    rearm    = state == S_DONE && (CONT != 0 || start);
    state_nx = state == S_IDLE ? (start ? S_WAIT : S_IDLE) :
               last ? S_DONE :
               begin_f ? (SKIP_LEN > 1 ? S_SKIP : S_WRITE) :
               (state == S_SKIP && data_valid && skip_cnt == SKIP_LAST) ? S_WRITE :
               rearm ? S_WAIT : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      skip_cnt <= '0;
      waddr    <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      wr_done  <= 1'b0;
      sof_err  <= 1'b0;
    end else begin
      state    <= state_nx;
      skip_cnt <= begin_f ? SW'(1) : (state == S_SKIP && data_valid) ? skip_cnt + 1'b1 : skip_cnt;
      waddr    <= wr_now ? addr_now + 1'b1 : (begin_f ? '0 : waddr);
      wr_en    <= wr_now;
      wr_addr  <= wr_now ? addr_now : wr_addr;
      wr_data  <= wr_now ? data_in : wr_data;
      wr_done  <= state == S_DONE && (CONT != 0 || !start);
      sof_err  <= restart;
    end
  end
  peak_track #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_peak (
    .clk       (clk),
    .rst       (rst),
    .clear     (begin_f || (state == S_DONE && CONT == 0 && start)),
    .load      (wr_now),
    .data      (data_in),
    .addr      (addr_now),
    .peak_val  (peak_val),
    .peak_addr (peak_addr)
  );
endmodule

// File: tb/tb_ram_wr_ctrl_frame.sv
// tb_ram_wr_ctrl_frame: scoreboard bench over default, skip and continuous configurations
module tb_ram_wr_ctrl_frame;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] st = '0, dv = '0, sf = '0;
  logic [2:0][15:0] di = '0;
  logic [2:0] we, done, busy, serr;
  logic [2:0][15:0] wd, pv;
  logic [2:0][7:0] wa, pa;
  logic [23:0] q[3][$];
  logic [23:0] exp_w;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  ram_wr_ctrl_frame u0 (
    .clk(clk), .rst(rst), .start(st[0]), .data_in(di[0]), .data_valid(dv[0]), .data_sof(sf[0]),
    .wr_data(wd[0]), .wr_addr(wa[0]), .wr_en(we[0]), .wr_done(done[0]), .busy(busy[0]),
    .peak_val(pv[0]), .peak_addr(pa[0]), .sof_err(serr[0]));
  ram_wr_ctrl_frame #(.FRAME_LEN(8), .SKIP_LEN(4)) u1 (
    .clk(clk), .rst(rst), .start(st[1]), .data_in(di[1]), .data_valid(dv[1]), .data_sof(sf[1]),
    .wr_data(wd[1]), .wr_addr(wa[1]), .wr_en(we[1]), .wr_done(done[1]), .busy(busy[1]),
    .peak_val(pv[1]), .peak_addr(pa[1]), .sof_err(serr[1]));
  ram_wr_ctrl_frame #(.FRAME_LEN(4), .CONT(1)) u2 (
    .clk(clk), .rst(rst), .start(st[2]), .data_in(di[2]), .data_valid(dv[2]), .data_sof(sf[2]),
    .wr_data(wd[2]), .wr_addr(wa[2]), .wr_en(we[2]), .wr_done(done[2]), .busy(busy[2]),
    .peak_val(pv[2]), .peak_addr(pa[2]), .sof_err(serr[2]));
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (we[i] === 1'b1) begin
        total++;
        if (q[i].size() == 0) begin
          bad++;
          $display("FAIL wr_unexpected inst=%0d got addr=%0d data=%0h, no write expected", i, wa[i], wd[i]);
        end else begin
          exp_w = q[i].pop_front();
          if ({wa[i], wd[i]} !== exp_w) begin
            bad++;
            $display("FAIL wr_beat inst=%0d got addr=%0d data=%0h expected addr=%0d data=%0h",
                     i, wa[i], wd[i], exp_w[23:16], exp_w[15:0]);
          end
        end
      end
    end
  end
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic arm(input int i);
    st[i] = 1'b1;
    idle(1);
    st[i] = 1'b0;
  endtask
  task automatic send(input int i, input logic v, input logic s, input logic [15:0] d,
                      input logic w, input logic [7:0] a);
    dv[i] = v;
    sf[i] = s;
    di[i] = d;
    if (w) q[i].push_back({a, d});
    @(posedge clk);
    #1;
    dv[i] = 1'b0;
    sf[i] = 1'b0;
  endtask
  task automatic test_reset();
    idle(2);
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({we[i], wa[i], wd[i], done[i], busy[i], pv[i], pa[i], serr[i]} !== 52'd0) begin
        bad++;
        $display("FAIL reset_outputs inst=%0d got %h expected 0", i,
                 {we[i], wa[i], wd[i], done[i], busy[i], pv[i], pa[i], serr[i]});
      end
    end
    rst = 1'b0;
    idle(1);
  endtask
  task automatic test_frame();
    logic [15:0] d, mp;
    logic [7:0] ma;
    mp = '0;
    ma = '0;
    arm(0);
    total++;
    if (busy[0] !== 1'b0) begin bad++; $display("FAIL busy_wait got %b expected 0", busy[0]); end
    for (int i = 0; i < 255; i++) begin
      d = 16'($urandom);
      send(0, 1'b1, i == 0, d, 1'b1, 8'(i));
      if (i == 0 || d > mp) begin mp = d; ma = 8'(i); end
      if (i == 0) begin
        total++;
        if (busy[0] !== 1'b1) begin bad++; $display("FAIL busy_write got %b expected 1", busy[0]); end
      end
    end
    total++;
    if (done[0] !== 1'b0) begin bad++; $display("FAIL done_early got %b expected 0", done[0]); end
    idle(1);
    total++;
    if ({done[0], pv[0], pa[0]} !== {1'b1, mp, ma}) begin
      bad++;
      $display("FAIL frame_done got done=%b peak=%0h@%0d expected done=1 peak=%0h@%0d", done[0], pv[0], pa[0], mp, ma);
    end
    for (int i = 0; i < 4; i++) begin
      send(0, 1'b1, 1'b1, 16'($urandom), 1'b0, 8'd0);
      total++;
      if ({done[0], serr[0], pv[0]} !== {1'b1, 1'b0, mp}) begin
        bad++;
        $display("FAIL done_hold got done=%b sof_err=%b peak=%0h expected 1 0 %0h", done[0], serr[0], pv[0], mp);
      end
    end
    arm(0);
    total++;
    if ({done[0], pv[0], pa[0]} !== 25'd0) begin
      bad++;
      $display("FAIL start_clear got done=%b peak=%0h@%0d expected all 0", done[0], pv[0], pa[0]);
    end
  endtask
  task automatic test_sof_restart();
    logic [15:0] d, mp;
    logic [7:0] ma;
    mp = '0;
    ma = '0;
    for (int i = 0; i < 100; i++) send(0, 1'b1, i == 0, 16'($urandom), 1'b1, 8'(i));
    for (int j = 0; j < 255; j++) begin
      d = 16'($urandom);
      send(0, 1'b1, j == 0, d, 1'b1, 8'(j));
      if (j == 0 || d > mp) begin mp = d; ma = 8'(j); end
      if (j == 0 || j == 1) begin
        total++;
        if (serr[0] !== (j == 0)) begin bad++; $display("FAIL sof_err_pulse j=%0d got %b expected %b", j, serr[0], j == 0); end
      end
      if (j == 200) begin
        total++;
        if ({done[0], busy[0]} !== 2'b01) begin bad++; $display("FAIL restart_midframe got done=%b busy=%b expected 0 1", done[0], busy[0]); end
      end
    end
    idle(1);
    total++;
    if ({done[0], pv[0], pa[0]} !== {1'b1, mp, ma}) begin
      bad++;
      $display("FAIL restart_done got done=%b peak=%0h@%0d expected done=1 peak=%0h@%0d", done[0], pv[0], pa[0], mp, ma);
    end
    arm(0);
  endtask
  task automatic test_skip();
    logic [15:0] d, mp;
    logic [7:0] ma;
    mp = '0;
    ma = '0;
    arm(1);
    for (int i = 0; i < 12; i++) begin
      d = 16'($urandom);
      send(1, 1'b1, i == 0, d, i >= 4, 8'(i - 4));
      if (i >= 4 && (i == 4 || d > mp)) begin mp = d; ma = 8'(i - 4); end
      if (i == 2) begin
        total++;
        if (busy[1] !== 1'b1) begin bad++; $display("FAIL busy_skip got %b expected 1", busy[1]); end
      end
      send(1, 1'b0, 1'b1, 16'($urandom), 1'b0, 8'd0);
    end
    total++;
    if ({done[1], busy[1], pv[1], pa[1]} !== {1'b1, 1'b0, mp, ma}) begin
      bad++;
      $display("FAIL skip_done got done=%b busy=%b peak=%0h@%0d expected 1 0 %0h@%0d", done[1], busy[1], pv[1], pa[1], mp, ma);
    end
  endtask
  task automatic test_peak();
    logic [15:0] tab [4] = '{16'd3, 16'd9, 16'd9, 16'd2};
    arm(2);
    for (int i = 0; i < 4; i++) send(2, 1'b1, i == 0, tab[i], 1'b1, 8'(i));
    idle(1);
    total++;
    if ({done[2], pv[2], pa[2]} !== {1'b1, 16'd9, 8'd1}) begin
      bad++;
      $display("FAIL peak_tie got done=%b peak=%0d@%0d expected 1 9@1", done[2], pv[2], pa[2]);
    end
    idle(1);
    total++;
    if ({done[2], pv[2], pa[2]} !== {1'b0, 16'd9, 8'd1}) begin
      bad++;
      $display("FAIL peak_hold got done=%b peak=%0d@%0d expected 0 9@1", done[2], pv[2], pa[2]);
    end
  endtask
  task automatic test_back_to_back();
    logic [15:0] tab [8] = '{16'd4, 16'd8, 16'd2, 16'd8, 16'd5, 16'd1, 16'd7, 16'd7};
    logic [7:0] pk_a [2] = '{8'd1, 8'd2};
    logic [15:0] pk_v [2] = '{16'd8, 16'd7};
    int cnt;
    cnt = 0;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 4; i++) send(2, 1'b1, i == 0, tab[f * 4 + i], 1'b1, 8'(i));
      repeat (3) begin
        idle(1);
        if (done[2] === 1'b1) cnt++;
      end
      total++;
      if ({pv[2], pa[2]} !== {pk_v[f], pk_a[f]}) begin
        bad++;
        $display("FAIL cont_peak f=%0d got %0d@%0d expected %0d@%0d", f, pv[2], pa[2], pk_v[f], pk_a[f]);
      end
    end
    total++;
    if (cnt != 2) begin bad++; $display("FAIL cont_done_pulses got %0d expected 2", cnt); end
  endtask
  task automatic test_reset_mid();
    arm(0);
    for (int i = 0; i < 51; i++) send(0, 1'b1, i == 0, 16'($urandom), 1'b1, 8'(i));
    rst = 1'b1;
    send(0, 1'b1, 1'b0, 16'($urandom), 1'b0, 8'd0);
    total++;
    if ({we[0], wa[0], wd[0], done[0], busy[0], pv[0], pa[0], serr[0]} !== 52'd0) begin
      bad++;
      $display("FAIL reset_mid got %h expected 0", {we[0], wa[0], wd[0], done[0], busy[0], pv[0], pa[0], serr[0]});
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) send(0, 1'b1, 1'b1, 16'($urandom), 1'b0, 8'd0);
    total++;
    if (busy[0] !== 1'b0) begin bad++; $display("FAIL reset_idle_busy got %b expected 0", busy[0]); end
    arm(0);
    for (int i = 0; i < 3; i++) send(0, 1'b1, i == 0, 16'($urandom), 1'b1, 8'(i));
  endtask
  initial begin
    test_reset();
    test_frame();
    test_sof_restart();
    test_skip();
    test_peak();
    test_back_to_back();
    test_reset_mid();
    idle(3);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (q[i].size() != 0) begin bad++; $display("FAIL missing_writes inst=%0d got %0d pending expected 0", i, q[i].size()); end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
